// File: rtl/toggle_cover_detector.sv
// Per-bit toggle coverage producer: pulses valid[i] once when bit i has been
// seen both rising and falling, and keeps a sticky bitmap and covered count.
module toggle_cover_detector #(
  parameter int WIDTH         = 42,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = $clog2(WIDTH + 1)
) (
  input  logic             gbl_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] valid,
  output logic [WIDTH-1:0] covered,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered,
  output logic             armed
);

  typedef enum logic [1:0] {
    SETTLE,
    CAPTURE,
    RUN
  } state_t;

  localparam int SC_W = (SETTLE_CYCLES > 1) ?
                        $clog2(SETTLE_CYCLES) : 1;
  localparam int LAST = (SETTLE_CYCLES > 0) ?
                        SETTLE_CYCLES - 1 : 0;

  state_t           state;
  logic [SC_W-1:0]  settle_cnt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise_seen;
  logic [WIDTH-1:0] fall_seen;

  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] nxt_cov;
  logic [WIDTH-1:0] new_cov;
  logic [CNT_W-1:0] new_cnt;
  logic             settle_done;

  function automatic logic [CNT_W-1:0] popcount(
    input logic [WIDTH-1:0] v
  );
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  assign settle_done = (SETTLE_CYCLES == 0) ||
                       (settle_cnt == SC_W'(LAST));

  // Edges only count while live and enabled; a completion on
  // the edge being sampled is folded in directly.
  always_comb begin
    rise_en = '0;
    fall_en = '0;
    if (state == RUN && enable) begin
      rise_en = ~prev & sig;
      fall_en = prev & ~sig;
    end
    nxt_cov = covered |
              ((rise_seen | rise_en) & (fall_seen | fall_en));
    new_cov = nxt_cov & ~covered;
    new_cnt = covered_count + popcount(new_cov);
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      state         <= SETTLE;
      settle_cnt    <= '0;
      prev          <= '0;
      rise_seen     <= '0;
      fall_seen     <= '0;
      covered       <= '0;
      valid         <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
      armed         <= 1'b0;
    end else if (clear) begin
      state         <= CAPTURE;
      settle_cnt    <= '0;
      rise_seen     <= '0;
      fall_seen     <= '0;
      covered       <= '0;
      valid         <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
      armed         <= 1'b0;
    end else begin
      valid <= '0;
      unique case (state)
        SETTLE: begin
          if (settle_done) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          prev  <= sig;
          state <= RUN;
          armed <= 1'b1;
        end
        RUN: begin
          prev          <= sig;
          rise_seen     <= rise_seen | rise_en;
          fall_seen     <= fall_seen | fall_en;
          covered       <= nxt_cov;
          valid         <= new_cov;
          covered_count <= new_cnt;
          all_covered   <= (new_cnt == CNT_W'(WIDTH));
        end
        default: begin
          state <= SETTLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_cover_detector.sv
// Bench for toggle_cover_detector: directed scenarios plus randomized
// traffic against a per-bit behavioural coverage model.
module tb_toggle_cover_detector;

  localparam int WIDTH = 42;
  localparam int SC    = 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             gbl_clk = 1'b0;
  logic             reset   = 1'b0;
  logic [WIDTH-1:0] sig     = '0;
  logic             enable  = 1'b0;
  logic             clear   = 1'b0;
  logic [WIDTH-1:0] valid;
  logic [WIDTH-1:0] covered;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;
  logic             armed;

  toggle_cover_detector #(
    .WIDTH(WIDTH),
    .SETTLE_CYCLES(SC)
  ) dut (
    .gbl_clk(gbl_clk),
    .reset(reset),
    .sig(sig),
    .enable(enable),
    .clear(clear),
    .valid(valid),
    .covered(covered),
    .covered_count(covered_count),
    .all_covered(all_covered),
    .armed(armed)
  );

  always #5 gbl_clk = ~gbl_clk;

  int checks   = 0;
  int failures = 0;

  // Model: per-bit "seen rise", "seen fall", "covered", pulse this cycle,
  // last sample, and posedges still to pass before edges are live.
  bit m_rs[WIDTH];
  bit m_fs[WIDTH];
  bit m_cov[WIDTH];
  bit m_val[WIDTH];
  bit m_prev[WIDTH];
  int m_wait = 0;

  task automatic model_edge();
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_rs[i] = 0; m_fs[i] = 0; m_cov[i] = 0;
        m_val[i] = 0; m_prev[i] = 0;
      end
      m_wait = ((SC > 1) ? SC : 1) + 1;
    end else if (clear) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_rs[i] = 0; m_fs[i] = 0; m_cov[i] = 0; m_val[i] = 0;
      end
      m_wait = 1;
    end else begin
      for (int i = 0; i < WIDTH; i++) m_val[i] = 0;
      if (m_wait > 0) begin
        if (m_wait == 1)
          for (int i = 0; i < WIDTH; i++) m_prev[i] = sig[i];
        m_wait--;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (enable && (m_prev[i] != sig[i])) begin
            if (sig[i]) m_rs[i] = 1;
            else        m_fs[i] = 1;
          end
          if (m_rs[i] && m_fs[i] && !m_cov[i]) begin
            m_cov[i] = 1;
            m_val[i] = 1;
          end
          m_prev[i] = sig[i];
        end
      end
    end
  endtask

  task automatic check_one(input string name,
                           input logic [63:0] act,
                           input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] ec;
    int n;
    ev = '0;
    ec = '0;
    n  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ev[i] = m_val[i];
      ec[i] = m_cov[i];
      if (m_cov[i]) n++;
    end
    check_one("valid", 64'(valid), 64'(ev));
    check_one("covered", 64'(covered), 64'(ec));
    check_one("count", 64'(covered_count), 64'(n));
    check_one("all_covered", 64'(all_covered), 64'(n == WIDTH));
    check_one("armed", 64'(armed), 64'(m_wait == 0));
  endtask

  task automatic step(input logic [WIDTH-1:0] s, input bit en,
                      input bit clr, input bit rst);
    @(negedge gbl_clk);
    sig    = s;
    enable = en;
    clear  = clr;
    reset  = rst;
    @(posedge gbl_clk);
    model_edge();
    #1;
    compare();
  endtask

  logic [WIDTH-1:0] rs;

  initial begin
    // T1: reset then settle
    repeat (3) step('0, 0, 0, 0);
    check_one("t1_armed_rst", 64'(armed), 64'd0);
    step('0, 1, 0, 1);
    check_one("t1_armed_c1", 64'(armed), 64'd0);
    step('0, 1, 0, 1);
    check_one("t1_armed_c2", 64'(armed), 64'd0);
    step('0, 1, 0, 1);
    check_one("t1_armed_c3", 64'(armed), 64'd1);
    check_one("t1_valid", 64'(valid), 64'd0);

    // T2: sig[3] full toggle
    step(42'h8, 1, 0, 1);
    check_one("t2_valid_rise", 64'(valid), 64'd0);
    step(42'h8, 1, 0, 1);
    step(42'h0, 1, 0, 1);
    check_one("t2_valid", 64'(valid), 64'h8);
    check_one("t2_count", 64'(covered_count), 64'd1);
    step(42'h0, 1, 0, 1);
    check_one("t2_valid_after", 64'(valid), 64'd0);

    // T3: repeated toggles ignored
    for (int k = 0; k < 5; k++)
      step((k % 2 == 0) ? 42'h8 : 42'h0, 1, 0, 1);
    step(42'h0, 1, 0, 1);
    check_one("t3_count", 64'(covered_count), 64'd1);

    // T4: every bit at once
    step({WIDTH{1'b1}}, 1, 0, 1);
    step('0, 1, 0, 1);
    check_one("t4_valid", 64'(valid), 64'h3FF_FFFF_FFF7);
    check_one("t4_count", 64'(covered_count), 64'd42);
    check_one("t4_all", 64'(all_covered), 64'd1);

    // T5: edges while disabled are lost
    step('0, 1, 1, 1);
    check_one("t5_clr_count", 64'(covered_count), 64'd0);
    check_one("t5_clr_armed", 64'(armed), 64'd0);
    step('0, 1, 0, 1);
    check_one("t5_rearmed", 64'(armed), 64'd1);
    step(42'h80, 0, 0, 1);
    step(42'h0, 0, 0, 1);
    step(42'h0, 1, 0, 1);
    check_one("t5_cov7", 64'(covered[7]), 64'd0);
    step(42'h80, 1, 0, 1);
    step(42'h0, 1, 0, 1);
    check_one("t5_valid7", 64'(valid), 64'h80);

    // T6: clear beats a completing toggle
    step(42'h200, 1, 0, 1);
    step(42'h0, 1, 1, 1);
    check_one("t6_valid", 64'(valid), 64'd0);
    check_one("t6_count", 64'(covered_count), 64'd0);
    check_one("t6_armed_drop", 64'(armed), 64'd0);
    step(42'h0, 1, 0, 1);
    check_one("t6_armed_back", 64'(armed), 64'd1);

    // randomized traffic
    rs = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < WIDTH; i++)
        if ($urandom_range(7) == 0) rs[i] = ~rs[i];
      step(rs,
           $urandom_range(9) != 0,
           $urandom_range(299) == 0,
           $urandom_range(499) != 0);
    end

    // reset mid-run
    repeat (6) step(rs ^ 42'h155, 1, 0, 1);
    step({WIDTH{1'b1}}, 1, 0, 0);
    check_one("rst_valid", 64'(valid), 64'd0);
    check_one("rst_covered", 64'(covered), 64'd0);
    check_one("rst_count", 64'(covered_count), 64'd0);
    check_one("rst_all", 64'(all_covered), 64'd0);
    check_one("rst_armed", 64'(armed), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
